// File: rtl/mac_pkg.sv
// Shared helpers for the multiply-accumulate engine: derived widths,
// saturation limits and the per-beat control tag that rides the pipeline.
package mac_pkg;

    // Control flags that travel alongside a beat's data through every stage
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_tag_t;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Width that holds the full-precision sum of all lane products
    function automatic int lane_sum_width(input int wa, input int wb, input int lanes);
        return wa + wb + clog2(lanes);
    endfunction

    // Largest representable value of a width-bit number (two's complement or unsigned)
    function automatic logic [63:0] sat_max(input int width, input bit is_signed);
        return is_signed ? ((64'd1 << (width - 1)) - 64'd1) : ((64'd1 << width) - 64'd1);
    endfunction

    // Smallest representable value, returned as a 64-bit two's-complement pattern
    function automatic logic [63:0] sat_min(input int width, input bit is_signed);
        return is_signed ? (~(64'd1 << (width - 1)) + 64'd1) : 64'd0;
    endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// One lane of the MAC: a full-precision multiplier followed by PIPELINE
// product registers, all advancing together on i_advance.
module mac_lane_mult
    import mac_pkg::*;
#(
    parameter int WIDTHA   = 8,
    parameter int WIDTHB   = 8,
    parameter int PIPELINE = 2,
    parameter int SIGNED   = 1
) (
    input  logic                     clock,
    input  logic                     aclr_n,
    input  logic                     i_advance,
    input  logic [WIDTHA-1:0]        i_a,
    input  logic [WIDTHB-1:0]        i_b,
    output logic [WIDTHA+WIDTHB-1:0] o_prod
);

    localparam int WP      = WIDTHA + WIDTHB;
    localparam bit SIGN_EN = (SIGNED != 0);

    logic [WP-1:0] w_a_ext;
    logic [WP-1:0] w_b_ext;
    logic [WP-1:0] w_prod;
    logic [WP-1:0] r_stage [PIPELINE];

    // Extending both operands to the product width makes the low WP bits of a
    // plain multiply equal to the true signed or unsigned product.
    assign w_a_ext = {{WIDTHB{SIGN_EN & i_a[WIDTHA-1]}}, i_a};
    assign w_b_ext = {{WIDTHA{SIGN_EN & i_b[WIDTHB-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Product delay line; the whole line freezes when the engine stalls
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            // NOTE: the stage array is a pipeline, not storage, so every entry is reset like a flop.
            for (int i = 0; i < PIPELINE; i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_advance) begin
            // NOTE: non-blocking assignments let every stage shift on the same edge.
            r_stage[0] <= w_prod;
            for (int i = 1; i < PIPELINE; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_prod = r_stage[PIPELINE-1];

endmodule

// File: rtl/mac_pipe.sv
// Multi-lane multiply-accumulate engine: LANES pipelined multipliers, a
// registered lane-sum stage and a saturating, first/last-framed accumulator
// with a valid/ready result port.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int WIDTHA   = 8,
    parameter int WIDTHB   = 8,
    parameter int WIDTHP   = 24,
    parameter int PIPELINE = 2,
    parameter int SIGNED   = 1
) (
    input  logic                      clock,
    input  logic                      aclr_n,
    input  logic                      clken,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [LANES*WIDTHA-1:0]   dataa,
    input  logic [LANES*WIDTHB-1:0]   datab,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTHP-1:0]         result,
    output logic                      overflow
);

    localparam int              WP      = WIDTHA + WIDTHB;
    localparam int              SUMW    = lane_sum_width(WIDTHA, WIDTHB, LANES);
    localparam bit              SIGN_EN = (SIGNED != 0);
    localparam logic [63:0]     C_MAX64 = sat_max(WIDTHP, SIGN_EN);
    localparam logic [63:0]     C_MIN64 = sat_min(WIDTHP, SIGN_EN);
    localparam logic [WIDTHP:0] C_MAX   = C_MAX64[WIDTHP:0];
    localparam logic [WIDTHP:0] C_MIN   = C_MIN64[WIDTHP:0];

    logic              w_stall;
    logic              w_advance;
    logic              w_load;
    logic [WP-1:0]     w_prod [LANES];
    logic [SUMW-1:0]   w_sum;
    logic [WIDTHP:0]   w_sum_ext;
    logic [WIDTHP:0]   w_base;
    logic [WIDTHP:0]   w_next;
    logic [WIDTHP-1:0] w_clamped;
    logic              w_sat;
    logic              w_ovf_next;

    beat_tag_t         r_tag [PIPELINE];
    beat_tag_t         r_sum_tag;
    logic [SUMW-1:0]   r_sum;
    logic [WIDTHP-1:0] r_acc;
    logic              r_ovf_acc;
    logic [WIDTHP-1:0] r_result;
    logic              r_overflow;
    logic              r_out_valid;

    // A held, unconsumed result or a disabled clock freezes every stage at once
    assign w_stall   = !clken || (r_out_valid && !out_ready);
    assign w_advance = !w_stall;
    assign in_ready  = w_advance;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mac_lane_mult #(
            .WIDTHA  (WIDTHA),
            .WIDTHB  (WIDTHB),
            .PIPELINE(PIPELINE),
            .SIGNED  (SIGNED)
        ) u_mult (
            .clock    (clock),
            .aclr_n   (aclr_n),
            .i_advance(w_advance),
            .i_a      (dataa[g*WIDTHA +: WIDTHA]),
            .i_b      (datab[g*WIDTHB +: WIDTHB]),
            .o_prod   (w_prod[g])
        );
    end

    // Control tags shadow the multiplier stages so flags stay aligned with data
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int i = 0; i < PIPELINE; i++) begin
                r_tag[i] <= '0;
            end
        end else if (w_advance) begin
            r_tag[0] <= '{valid: in_valid, first: in_first, last: in_last};
            for (int i = 1; i < PIPELINE; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Full-precision lane sum; synthesis balances the chain into a tree
    always_comb begin
        logic [SUMW-1:0] v_ext;
        // NOTE: defaulting every comb output first is what keeps this block latch-free.
        w_sum = '0;
        v_ext = '0;
        for (int i = 0; i < LANES; i++) begin
            v_ext          = {SUMW{SIGN_EN & w_prod[i][WP-1]}};
            v_ext[WP-1:0]  = w_prod[i];
            w_sum          = w_sum + v_ext;
        end
    end

    // Registered adder-tree stage
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_sum     <= '0;
            r_sum_tag <= '0;
        end else if (w_advance) begin
            r_sum     <= w_sum;
            r_sum_tag <= r_tag[PIPELINE-1];
        end
    end

    // One extra bit of headroom makes any out-of-range sum visible before clamping
    always_comb begin
        w_sum_ext             = {(WIDTHP+1){SIGN_EN & r_sum[SUMW-1]}};
        w_sum_ext[SUMW-1:0]   = r_sum;
        w_base                = r_sum_tag.first ? '0 : {SIGN_EN & r_acc[WIDTHP-1], r_acc};
        w_next                = w_base + w_sum_ext;
        w_sat                 = 1'b0;
        w_clamped             = w_next[WIDTHP-1:0];
        if (SIGN_EN) begin
            if ($signed(w_next) > $signed(C_MAX)) begin
                w_sat     = 1'b1;
                w_clamped = C_MAX[WIDTHP-1:0];
            end else if ($signed(w_next) < $signed(C_MIN)) begin
                w_sat     = 1'b1;
                w_clamped = C_MIN[WIDTHP-1:0];
            end
        end else if (w_next > C_MAX) begin
            w_sat     = 1'b1;
            w_clamped = C_MAX[WIDTHP-1:0];
        end
        w_ovf_next = w_sat || (!r_sum_tag.first && r_ovf_acc);
    end

    assign w_load = w_advance && r_sum_tag.valid && r_sum_tag.last;

    // Accumulator, result register and output handshake
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_acc       <= '0;
            r_ovf_acc   <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clken) begin
            if (w_load) begin
                r_result    <= w_clamped;
                r_overflow  <= w_ovf_next;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_ovf_acc   <= 1'b0;
            end else begin
                if (w_advance && r_sum_tag.valid) begin
                    r_acc     <= w_clamped;
                    r_ovf_acc <= w_ovf_next;
                end
                if (r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_mac_pipe.sv
// Scoreboard bench for mac_pipe: a signed and an unsigned instance share the
// same stimulus; a behavioural model pushes expected results at acceptance
// and a negedge monitor pops and compares them on every output transfer.
module tb_mac_pipe;

    localparam longint S_MAX = 64'sd8388607;
    localparam longint S_MIN = -64'sd8388608;
    localparam longint U_MAX = 64'sd16777215;

    logic        clock;
    logic        aclr_n;
    logic        clken;
    logic        in_valid;
    logic        in_first;
    logic        in_last;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        out_ready;

    logic        in_ready,  in_ready_u;
    logic        out_valid, out_valid_u;
    logic        overflow,  overflow_u;
    logic [23:0] result,    result_u;

    typedef struct {
        longint res_s;
        bit     ovf_s;
        longint res_u;
        bit     ovf_u;
    } exp_t;

    exp_t   sb_q[$];
    longint m_acc_s;
    longint m_acc_u;
    bit     m_ovf_s;
    bit     m_ovf_u;
    int     n_checks;
    int     n_errors;
    int     n_xfer;

    mac_pipe #(
        .LANES(4), .WIDTHA(8), .WIDTHB(8), .WIDTHP(24), .PIPELINE(2), .SIGNED(1)
    ) u_dut (
        .clock(clock), .aclr_n(aclr_n), .clken(clken),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
        .dataa(dataa), .datab(datab),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow)
    );

    mac_pipe #(
        .LANES(4), .WIDTHA(8), .WIDTHB(8), .WIDTHP(24), .PIPELINE(2), .SIGNED(0)
    ) u_dut_u (
        .clock(clock), .aclr_n(aclr_n), .clken(clken),
        .in_valid(in_valid), .in_ready(in_ready_u), .in_first(in_first), .in_last(in_last),
        .dataa(dataa), .datab(datab),
        .out_valid(out_valid_u), .out_ready(out_ready), .result(result_u), .overflow(overflow_u)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] pack4(input logic [7:0] x0, input logic [7:0] x1,
                                          input logic [7:0] x2, input logic [7:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_acc_s = 0;
        m_acc_u = 0;
        m_ovf_s = 1'b0;
        m_ovf_u = 1'b0;
    endtask

    // Reference accumulation in plain integer arithmetic
    task automatic model_accept(input logic [31:0] a, input logic [31:0] b,
                                input bit f, input bit l);
        longint sum_s;
        longint sum_u;
        exp_t   e;
        sum_s = 0;
        sum_u = 0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] la;
            logic [7:0] lb;
            la = a[i*8 +: 8];
            lb = b[i*8 +: 8];
            sum_s += longint'($signed(la)) * longint'($signed(lb));
            sum_u += longint'(la) * longint'(lb);
        end
        if (f) begin
            m_acc_s = 0;
            m_acc_u = 0;
            m_ovf_s = 1'b0;
            m_ovf_u = 1'b0;
        end
        m_acc_s += sum_s;
        m_acc_u += sum_u;
        if (m_acc_s > S_MAX) begin
            m_acc_s = S_MAX;
            m_ovf_s = 1'b1;
        end else if (m_acc_s < S_MIN) begin
            m_acc_s = S_MIN;
            m_ovf_s = 1'b1;
        end
        if (m_acc_u > U_MAX) begin
            m_acc_u = U_MAX;
            m_ovf_u = 1'b1;
        end
        if (l) begin
            e.res_s = m_acc_s;
            e.ovf_s = m_ovf_s;
            e.res_u = m_acc_u;
            e.ovf_u = m_ovf_u;
            sb_q.push_back(e);
            m_acc_s = 0;
            m_acc_u = 0;
            m_ovf_s = 1'b0;
            m_ovf_u = 1'b0;
        end
    endtask

    // Present one beat and hold it until accepted (bounded wait)
    task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                             input bit f, input bit l);
        int waited;
        waited   = 0;
        dataa    = a;
        datab    = b;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check("accept", longint'(in_ready), 1);
        if (in_ready) begin
            model_accept(a, b, f, l);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (sb_q.size() != 0 && c < 300) begin
            @(posedge clock);
            c++;
        end
        check("drain", longint'(sb_q.size()), 0);
        @(posedge clock);
        #1;
    endtask

    // Output monitor: a transfer completes at the next rising edge
    always @(negedge clock) begin
        if (aclr_n && clken && out_valid && out_ready) begin
            exp_t e;
            n_xfer++;
            check("valid_u", longint'(out_valid_u), 1);
            if (sb_q.size() == 0) begin
                check("spurious_out", longint'(out_valid), 0);
            end else begin
                e = sb_q.pop_front();
                check("result_s",   longint'($signed(result)), e.res_s);
                check("overflow_s", longint'(overflow),        longint'(e.ovf_s));
                check("result_u",   longint'(result_u),        e.res_u);
                check("overflow_u", longint'(overflow_u),      longint'(e.ovf_u));
            end
        end
    end

    initial begin
        int lat;
        int xfer_base;
        n_checks  = 0;
        n_errors  = 0;
        n_xfer    = 0;
        aclr_n    = 1'b0;
        clken     = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        dataa     = '0;
        datab     = '0;
        out_ready = 1'b1;
        model_reset();

        // Reset state
        #12;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_result",    longint'(result),    0);
        check("rst_overflow",  longint'(overflow),  0);
        check("rst_in_ready",  longint'(in_ready),  1);
        check("rst_valid_u",   longint'(out_valid_u), 0);
        @(negedge clock);
        aclr_n = 1'b1;
        @(posedge clock);
        #1;

        // Single-beat frame and its latency
        send_beat(pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1, 1'b1);
        lat = 0;
        @(negedge clock);
        while (!out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("latency", longint'(lat), 3);
        wait_drain();

        // Three back-to-back beats, then a clken hold before the result appears
        send_beat({4{8'h7F}}, {4{8'h7F}}, 1'b1, 1'b0);
        send_beat({4{8'h7F}}, {4{8'h7F}}, 1'b0, 1'b0);
        send_beat({4{8'h7F}}, {4{8'h7F}}, 1'b0, 1'b1);
        clken = 1'b0;
        repeat (5) @(negedge clock);
        check("hold_in_ready",  longint'(in_ready),  0);
        check("hold_out_valid", longint'(out_valid), 0);
        @(posedge clock);
        #1;
        clken = 1'b1;
        wait_drain();

        // Sign handling: -128*127 and 255*255 on every lane
        send_beat({4{8'h80}}, {4{8'h7F}}, 1'b1, 1'b1);
        send_beat({4{8'hFF}}, {4{8'hFF}}, 1'b1, 1'b1);
        wait_drain();

        // Saturation over 131 beats, then a clean frame clears overflow
        for (int i = 0; i < 131; i++) begin
            send_beat({4{8'h7F}}, {4{8'h7F}}, (i == 0), (i == 130));
        end
        send_beat(pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1, 1'b1);
        wait_drain();

        // Backpressure: two frames queue up behind a stalled consumer
        out_ready = 1'b0;
        xfer_base = n_xfer;
        send_beat(pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1, 1'b1);
        send_beat({4{8'h01}}, {4{8'h01}}, 1'b1, 1'b1);
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("bp_out_valid",  longint'(out_valid),  1);
        check("bp_in_ready",   longint'(in_ready),   0);
        check("bp_in_ready_u", longint'(in_ready_u), 0);
        check("bp_result_held", longint'($signed(result)), 70);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        wait_drain();
        repeat (3) @(posedge clock);
        #1;
        check("bp_transfers", longint'(n_xfer - xfer_base), 2);
        check("bp_idle", longint'(out_valid), 0);

        // Asynchronous reset mid-frame discards the in-flight work
        send_beat(pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1, 1'b1);
        send_beat({4{8'h7F}}, {4{8'h7F}}, 1'b1, 1'b0);
        send_beat({4{8'h7F}}, {4{8'h7F}}, 1'b0, 1'b0);
        @(posedge clock);
        #2;
        check("pre_rst_out_valid", longint'(out_valid), 1);
        aclr_n = 1'b0;
        #1;
        check("arst_out_valid", longint'(out_valid),   0);
        check("arst_result",    longint'(result),      0);
        check("arst_overflow",  longint'(overflow),    0);
        check("arst_valid_u",   longint'(out_valid_u), 0);
        check("arst_result_u",  longint'(result_u),    0);
        check("arst_in_ready",  longint'(in_ready),    1);
        model_reset();
        @(negedge clock);
        aclr_n = 1'b1;
        @(posedge clock);
        #1;
        send_beat(pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1, 1'b1);
        wait_drain();

        check("final_queue", longint'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_pipe.md
# mac_pipe

Parametrised, pipelined multi-lane multiply-accumulate engine and the next generation of the team's single-product multiplier. Each accepted beat multiplies LANES operand pairs, sums the products in a registered adder tree and adds the sum into a saturating accumulator. Framing with first/last delimits one dot product, such as one convolution window. It feeds the CNN conv/FC datapath and sits between the operand fetch logic and the requantise stage.

## Interface
- LANES, 4: operand pairs per beat, ≥1.
- WIDTHA, 8: width of each dataa lane.
- WIDTHB, 8: width of each datab lane.
- WIDTHP, 24: accumulator and result width. Must be ≥ WIDTHA+WIDTHB+clog2(LANES).
- PIPELINE, 2: multiplier register stages, ≥1.
- SIGNED, 1: 1 selects two's-complement operands and result; 0 selects unsigned.

Ports:
- clock, in, 1: single clock. All logic is rising-edge.
- aclr_n, in, 1: asynchronous, active-low reset.
- clken, in, 1: global clock enable. When 0, the whole block holds state.
- in_valid, in, 1: beat present.
- in_ready, out, 1: block accepts a beat this cycle.
- in_first, in, 1: beat starts a new accumulation.
- in_last, in, 1: beat ends the accumulation and produces a result.
- dataa, in, LANES*WIDTHA: lane i occupies bits [i*WIDTHA +: WIDTHA].
- datab, in, LANES*WIDTHB: same packing as dataa.
- out_valid, out, 1: result held.
- out_ready, in, 1: consumer takes the result.
- result, out, WIDTHP: saturated dot product.
- overflow, out, 1: saturation occurred at least once during this result's accumulation.

## Operation
- Reset (aclr_n=0): all pipeline valids, accumulator, result, overflow and out_valid go to 0 immediately. in_ready then follows clken.
- stall = !clken | (out_valid & !out_ready). in_ready = !stall. The pipeline advances only when stall=0.
- A beat is accepted when in_valid & in_ready. Its first/last flags travel alongside the data.
- Products are full precision, WIDTHA+WIDTHB bits, signed or unsigned per SIGNED. Lane sum is full precision, WIDTHA+WIDTHB+clog2(LANES) bits, extended to WIDTHP.
- Accumulate step:
  - base = 0 if the beat has first, otherwise base = acc.
  - next = base + sum, computed at WIDTHP+1 bits.
  - If next is out of range, clamp it and set the overflow bit. Range is [-2^(WIDTHP-1), 2^(WIDTHP-1)-1] when signed, [0, 2^WIDTHP-1] when unsigned.
  - The overflow bit is cleared on first, otherwise OR-accumulated.
- On last:
  - The result register loads the clamped next value, overflow loads the accumulated flag, and out_valid is set.
  - acc and the overflow bit clear to 0.
  - A beat carrying both first and last is a single-beat result.
- A beat without first that follows a last accumulates from 0.
- Output handshake:
  - Transfer happens when out_valid & out_ready.
  - If another last completes on the same edge as a transfer, the result register reloads and out_valid stays 1.
  - Otherwise out_valid drops after the transfer.
- Bubbles (in_valid=0) leave acc unchanged.

## Timing
- A beat accepted at edge k passes through these registers:
  - Multiplier stages at edges k .. k+PIPELINE-1.
  - Adder-tree register at edge k+PIPELINE.
  - acc and the result register at edge k+PIPELINE+1.
- out_valid is observed high PIPELINE+1 cycles after the accepting edge, counting only non-stalled cycles.
- Throughput is one beat per cycle while out_ready=1.
- Stall freezes every stage in the same cycle, so no beat is lost or duplicated.
- in_ready is combinational from out_valid, out_ready and clken only.
- Deasserting aclr_n mid-accumulation discards all in-flight beats. The first post-reset beat must carry in_first; the block does not check this.

## Structure
- Package mac_pkg holds:
  - the clog2 constant function;
  - saturation-limit functions parameterised by width and signedness;
  - a derived-width helper for the lane-sum width.
- Sub-module mac_lane_mult is one pipelined multiplier (WIDTHA, WIDTHB, PIPELINE, SIGNED). It takes clock, aclr_n and an advance enable, and is instantiated LANES times.
- The adder tree, accumulator, saturation and output handshake stay in mac_pipe.

## Test plan
All scenarios use the defaults (LANES=4, 8x8, WIDTHP=24, SIGNED=1, PIPELINE=2) unless stated.
- Single beat, first=last=1, a={1,2,3,4}, b={5,6,7,8} -> result=70, overflow=0, out_valid 3 cycles after acceptance.
- Three back-to-back beats, all lanes a=b=127, first on beat 0, last on beat 2 -> result=193548.
- Signed check: single beat, all a=-128, b=127 -> result=-65024. With SIGNED=0, a=255 and b=255 on all lanes -> 260100.
- Saturation: 131 beats, all lanes a=b=127 -> result=8388607, overflow=1. The next 1-beat frame of a={1,2,3,4}, b={5,6,7,8} -> 70, overflow=0.
- Backpressure: hold out_ready=0 while two single-beat frames (70, then 4) are sent.
  - in_ready drops once the first result is held.
  - Raising out_ready delivers 70 then 4, with no loss or duplication.
- Pull aclr_n low mid-frame, after 2 of 3 beats -> all outputs 0 asynchronously. A new frame {1,2,3,4}·{5,6,7,8} then -> 70.
